// File: rtl/ext_pkg.sv
// Shared types and helpers for the LC-3b immediate/offset extractor.
// Field selector encoding, field widths and a generic sign/zero extender.
package ext_pkg;

    typedef enum logic [2:0] {
        EXT_IMM5    = 3'd0,
        EXT_OFF6    = 3'd1,
        EXT_PCOFF9  = 3'd2,
        EXT_PCOFF11 = 3'd3,
        EXT_TRAP8   = 3'd4,
        EXT_AMT4    = 3'd5,
        EXT_ZERO    = 3'd6,
        EXT_RSVD    = 3'd7
    } ext_sel_e;

    localparam int IMM5_W      = 5;
    localparam int OFF6_W      = 6;
    localparam int PCOFF9_W    = 9;
    localparam int PCOFF11_W   = 11;
    localparam int TRAP8_W     = 8;
    localparam int AMT4_W      = 4;
    localparam int EXT_FIELD_W = PCOFF11_W;
    // Widest result the extender can produce; OUT_W must not exceed it.
    localparam int EXT_MAX_W   = 64;

    // Keeps the low 'width' bits of field; fills the rest with the field MSB
    // when sign_en is set, else with zeros. width == 0 yields all zeros.
    function automatic logic [EXT_MAX_W-1:0] sext_field(
        input logic [EXT_FIELD_W-1:0] field,
        input logic [3:0]             width,
        input logic                   sign_en
    );
        logic [EXT_MAX_W-1:0] raw;
        logic [EXT_MAX_W-1:0] hi_mask;
        logic [EXT_MAX_W-1:0] res;
        logic [5:0]           msb_idx;
        raw     = {{(EXT_MAX_W-EXT_FIELD_W){1'b0}}, field};
        hi_mask = {EXT_MAX_W{1'b1}} << width;
        msb_idx = {2'b00, width - 4'd1};
        res     = raw & ~hi_mask;
        if (sign_en && (width != 4'd0) && raw[msb_idx]) begin
            res = res | hi_mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry valid/ready buffer: a head register driving the outputs plus one skid slot.
// in_ready is registered, so there is no combinational path from out_ready to in_ready.
module ext_skid_buf #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a word moves on a rising edge when valid && ready on that side;
    // the producer side never depends on the consumer in the same cycle, and the
    // head word is held unchanged while out_valid=1 and out_ready=0.
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_vld_q, head_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire;
    logic         out_fire;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        in_fire    = in_valid && in_ready_q;
        out_fire   = head_vld_q && out_ready;

        if (!head_vld_q || out_fire) begin
            // Head slot frees up: the older skid word goes first, keeping order.
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = in_fire;
                if (in_fire) begin
                    skid_d = in_data;
                end
            end else if (in_fire) begin
                head_d     = in_data;
                head_vld_d = 1'b1;
            end else begin
                // Data is left alone so the last popped word stays visible.
                head_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d     = in_data;
            skid_vld_d = 1'b1;
        end

        in_ready_d = !(head_vld_d && skid_vld_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = head_vld_q;
    assign out_data  = head_q;

endmodule

// File: rtl/ext_unit.sv
// LC-3b decode immediate/offset extractor: field select, sign/zero extend, skid-buffered output.
// Define EXT_LSHF_EN to honour in_lshf1 (result << 1); otherwise in_lshf1 is ignored.
import ext_pkg::*;

module ext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_instr,
    input  logic [2:0]       in_sel,
    input  logic             in_lshf1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int BUF_W = OUT_W + TAG_W + 1;

    ext_sel_e             sel;
    logic [3:0]           fld_width;
    logic                 fld_signed;
    logic                 sel_err;
    logic [EXT_MAX_W-1:0] ext_full;
    logic [OUT_W-1:0]     ext_data;
    logic [BUF_W-1:0]     buf_out;
    logic                 unused_bits;

    always_comb begin
        sel        = ext_sel_e'(in_sel);
        fld_width  = 4'd0;
        fld_signed = 1'b0;
        sel_err    = 1'b0;
        case (sel)
            EXT_IMM5:    begin fld_width = 4'(IMM5_W);    fld_signed = 1'b1; end
            EXT_OFF6:    begin fld_width = 4'(OFF6_W);    fld_signed = 1'b1; end
            EXT_PCOFF9:  begin fld_width = 4'(PCOFF9_W);  fld_signed = 1'b1; end
            EXT_PCOFF11: begin fld_width = 4'(PCOFF11_W); fld_signed = 1'b1; end
            EXT_TRAP8:   fld_width = 4'(TRAP8_W);
            EXT_AMT4:    fld_width = 4'(AMT4_W);
            EXT_ZERO:    fld_width = 4'd0;
            EXT_RSVD:    sel_err   = 1'b1;
        endcase

        // Zero width leaves ZERO and reserved selectors at all-zero data.
        ext_full = sext_field(in_instr[EXT_FIELD_W-1:0], fld_width, fld_signed);
        ext_data = ext_full[OUT_W-1:0];
`ifdef EXT_LSHF_EN
        if (in_lshf1) begin
            ext_data = {ext_data[OUT_W-2:0], 1'b0};
        end
`endif
    end

    // Upper instruction bits, high extender bits and (without the shifter) in_lshf1 are not needed.
    assign unused_bits = ^{in_instr, ext_full, in_lshf1};

    ext_skid_buf #(
        .W(BUF_W)
    ) u_skid_buf (
        .clk      (clk_50),
        .rst_n    (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({sel_err, in_tag, ext_data}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign {out_err, out_tag, out_data} = buf_out;

endmodule
